uart_boot_loader: RTL and testbench
===================================

UART_BOOT_LOADER -- requirements
Module: uart_boot_loader

Interface
REQ-001 SHALL have parameter UART_BASE, default 32'h00002000, meaning base address of the UART register block (DATA at +0, STATUS at +4).
REQ-002 SHALL have parameter LOAD_BASE, default 32'h00000000, meaning byte address of the first loaded word.
REQ-003 SHALL have parameter MAX_WORDS, default 1024, meaning largest accepted payload length in words.
REQ-004 SHALL have ports, one per line:
  clk  input  1  single clock; all logic is on its rising edge
  reset  input  1  asynchronous, active-high reset
  start  input  1  one-cycle load request
  busy  output  1  high from accepted start until done/error pulse
  done  output  1  one-cycle pulse on successful completion
  error  output  1  one-cycle pulse on rejected length
  address  output  32  bus address to UART
  write_data  output  32  bus write data to UART
  mem_write  output  1  bus write strobe
  mem_read  output  1  bus read strobe (a DATA read pops one RX byte)
  read_data  input  32  UART read data, combinational in the same cycle as mem_read
  ld_addr  output  32  target memory word address
  ld_wdata  output  32  target memory write data
  ld_we  output  1  target memory write strobe

Function
REQ-005 SHALL be a bus initiator for the UART: STATUS bit0 = rx_empty, bit1 = tx_full; a DATA read returns the RX byte in [7:0]; a DATA write sends write_data[7:0].
REQ-006 SHALL implement states IDLE, POLL_RX, READ_BYTE, WRITE_MEM, POLL_TX, SEND_RESP, FINISH.
REQ-007 IDLE: start=1 -> POLL_RX, busy=1, byte/word counters cleared, header phase set; start while busy SHALL be ignored.
REQ-008 POLL_RX: address=UART_BASE+4, mem_read=1 each cycle; read_data[0]=0 -> READ_BYTE next cycle, else remain.
REQ-009 READ_BYTE: address=UART_BASE, mem_read=1 for exactly one cycle; read_data[7:0] SHALL be stored as byte (byte_idx) of a little-endian word; byte_idx wraps 3->0.
REQ-010 Header: the first 4 bytes SHALL form LEN (words); LEN=0 -> POLL_TX with ACK; LEN>MAX_WORDS -> POLL_TX with NAK.
REQ-011 Payload: each completed word -> WRITE_MEM for one cycle, with ld_we=1, ld_addr=LOAD_BASE+4*word_idx, ld_wdata=assembled word; then word_idx+1; word_idx==LEN -> POLL_TX (ACK), else POLL_RX.
REQ-012 POLL_TX: address=UART_BASE+4, mem_read=1; read_data[1]=0 -> SEND_RESP, else remain.
REQ-013 SEND_RESP: address=UART_BASE, write_data={24'b0,8'h06} (ACK) or {24'b0,8'h15} (NAK), mem_write=1 for exactly one cycle.
REQ-014 FINISH: done=1 (ACK) or error=1 (NAK) for one cycle, busy=0 from the next cycle, -> IDLE.
REQ-015 mem_read and mem_write SHALL never be high together; address/write_data SHALL be 0 when no strobe is active.
REQ-016 ld_we SHALL be high only in WRITE_MEM; ld_addr/ld_wdata SHALL be 0 otherwise.
REQ-017 word_idx SHALL be wide enough for MAX_WORDS without wrap; address arithmetic SHALL be 32-bit, modulo 2^32.
REQ-018 Minimum latency per payload byte SHALL be 2 cycles (poll + read) plus 1 WRITE_MEM cycle per word.

Reset
REQ-019 reset=1 SHALL at any time, including mid-load, force IDLE, all outputs 0, all counters, LEN and word register 0, without a response byte.

Structure
REQ-020 Package uart_loader_pkg SHALL hold the state enum, register offsets (DATA=0, STATUS=4), status bit indices (RX_EMPTY=0, TX_FULL=1) and the ACK/NAK constants.
REQ-021 Single module; no sub-module required.

Verification
REQ-022 Load: LEN=2, bytes 78 56 34 12 EF BE AD DE -> ld_we at 0x0 (0x12345678) and 0x4 (0xDEADBEEF), then DATA write 0x06, done pulse.
REQ-023 Empty: LEN=0 -> no ld_we, ACK 0x06, done pulse.
REQ-024 Oversize: LEN=1025 -> no ld_we, NAK 0x15, error pulse, busy low afterwards.
REQ-025 Backpressure: rx_empty held 1 for 50 cycles mid-word, then tx_full held 1 for 20 cycles -> no DATA reads during rx stall, no DATA write before tx_full=0, word content intact.
REQ-026 Reset mid-load: reset after word 0 of LEN=4 -> all outputs 0 the following cycle; a new start then loads from LOAD_BASE with a fresh header.
REQ-027 start re-asserted while busy -> ignored, strobes never overlap (assertion over all tests).

Source files
------------

// File: rtl/uart_loader_pkg.sv
// Shared definitions for the UART boot loader: FSM states,
// UART register map, status bits and response bytes.
package uart_loader_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    POLL_RX   = 3'd1,
    READ_BYTE = 3'd2,
    WRITE_MEM = 3'd3,
    POLL_TX   = 3'd4,
    SEND_RESP = 3'd5,
    FINISH    = 3'd6
  } state_e;

  localparam logic [31:0] REG_DATA   = 32'h0000_0000;
  localparam logic [31:0] REG_STATUS = 32'h0000_0004;

  localparam int RX_EMPTY = 0;
  localparam int TX_FULL  = 1;

  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;

endpackage

// File: rtl/uart_boot_loader.sv
// UART boot loader: polls a UART for a length-prefixed word stream,
// writes it to target memory and answers with ACK or NAK.
module uart_boot_loader
  import uart_loader_pkg::*;
#(
  parameter logic [31:0] UART_BASE = 32'h0000_2000,
  parameter logic [31:0] LOAD_BASE = 32'h0000_0000,
  parameter int          MAX_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [31:0] address,
  output logic [31:0] write_data,
  output logic        mem_write,
  output logic        mem_read,
  input  logic [31:0] read_data,
  output logic [31:0] ld_addr,
  output logic [31:0] ld_wdata,
  output logic        ld_we
);

  localparam int          WIW  = $clog2(MAX_WORDS + 1);
  localparam logic [31:0] MAXW = 32'(MAX_WORDS);

  state_e         state_q, state_d;
  logic [1:0]     byte_q, byte_d;
  logic [WIW-1:0] widx_q, widx_d;
  logic [31:0]    len_q, len_d;
  logic [31:0]    word_q, word_d;
  logic           hdr_q, hdr_d;
  logic           nak_q, nak_d;

  logic [31:0]    asm_w;
  logic [WIW-1:0] widx_inc;
  logic           unused_rd;

  assign unused_rd = ^read_data[31:8];
  assign widx_inc  = widx_q + WIW'(1);

  always_comb begin
    asm_w = word_q;
    asm_w[{byte_q, 3'b000} +: 8] = read_data[7:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      byte_q  <= '0;
      widx_q  <= '0;
      len_q   <= '0;
      word_q  <= '0;
      hdr_q   <= 1'b0;
      nak_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      byte_q  <= byte_d;
      widx_q  <= widx_d;
      len_q   <= len_d;
      word_q  <= word_d;
      hdr_q   <= hdr_d;
      nak_q   <= nak_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    byte_d     = byte_q;
    widx_d     = widx_q;
    len_d      = len_q;
    word_d     = word_q;
    hdr_d      = hdr_q;
    nak_d      = nak_q;
    done       = 1'b0;
    error      = 1'b0;
    address    = '0;
    write_data = '0;
    mem_write  = 1'b0;
    mem_read   = 1'b0;
    ld_addr    = '0;
    ld_wdata   = '0;
    ld_we      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = POLL_RX;
          byte_d  = '0;
          widx_d  = '0;
          len_d   = '0;
          word_d  = '0;
          hdr_d   = 1'b1;
          nak_d   = 1'b0;
        end
      end
      POLL_RX: begin
        mem_read = 1'b1;
        address  = UART_BASE + REG_STATUS;
        if (!read_data[RX_EMPTY]) state_d = READ_BYTE;
      end
      READ_BYTE: begin
        mem_read = 1'b1;
        address  = UART_BASE + REG_DATA;
        word_d   = asm_w;
        byte_d   = byte_q + 2'd1;
        state_d  = POLL_RX;
        if (byte_q == 2'd3) begin
          if (hdr_q) begin
            // Header word is the payload length in words.
            len_d = asm_w;
            hdr_d = 1'b0;
            if (asm_w == '0) begin
              state_d = POLL_TX;
            end else if (asm_w > MAXW) begin
              nak_d   = 1'b1;
              state_d = POLL_TX;
            end
          end else begin
            state_d = WRITE_MEM;
          end
        end
      end
      WRITE_MEM: begin
        ld_we    = 1'b1;
        ld_addr  = LOAD_BASE + (32'(widx_q) << 2);
        ld_wdata = word_q;
        widx_d   = widx_inc;
        state_d  = (32'(widx_inc) == len_q) ? POLL_TX : POLL_RX;
      end
      POLL_TX: begin
        mem_read = 1'b1;
        address  = UART_BASE + REG_STATUS;
        if (!read_data[TX_FULL]) state_d = SEND_RESP;
      end
      SEND_RESP: begin
        mem_write  = 1'b1;
        address    = UART_BASE + REG_DATA;
        write_data = {24'b0, (nak_q ? NAK : ACK)};
        state_d    = FINISH;
      end
      FINISH: begin
        done    = !nak_q;
        error   = nak_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_boot_loader.sv
// Scoreboard bench for uart_boot_loader with a behavioural UART
// model, randomized payloads and random RX/TX backpressure.
module tb_uart_boot_loader;

  localparam logic [31:0] UB = 32'h0000_2000;
  localparam logic [31:0] LB = 32'h0000_0000;
  localparam int          MW = 1024;

  logic        clk, reset, start;
  logic        busy, done, error;
  logic [31:0] address, write_data, read_data;
  logic        mem_write, mem_read;
  logic [31:0] ld_addr, ld_wdata;
  logic        ld_we;

  uart_boot_loader dut (
    .clk(clk), .reset(reset), .start(start),
    .busy(busy), .done(done), .error(error),
    .address(address), .write_data(write_data),
    .mem_write(mem_write), .mem_read(mem_read),
    .read_data(read_data),
    .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_we(ld_we)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // UART model: RX byte stream plus status flags.
  logic [7:0] rx_mem [16384];
  int         rx_len = 0;
  int         rd_ptr = 0;
  logic       stall_dir = 0, stall_rnd = 0;
  logic       txf_dir = 0, txf_rnd = 0;
  logic       rand_bp = 0;
  int         stall_age = 0, txf_age = 0;
  logic       rxe, txf;

  assign rxe = stall_dir || stall_rnd || (rd_ptr >= rx_len);
  assign txf = txf_dir || txf_rnd;

  always_comb begin
    read_data = 32'h0;
    if (mem_read && address == UB + 32'h4)
      read_data = {30'b0, txf, rxe};
    else if (mem_read && address == UB)
      read_data = {24'b0, rx_mem[rd_ptr[13:0]]};
  end

  always @(posedge clk) begin
    if (mem_read && address == UB) rd_ptr <= rd_ptr + 1;
    stall_rnd <= rand_bp && ($urandom_range(0, 3) == 0);
    txf_rnd   <= rand_bp && ($urandom_range(0, 2) == 0);
    stall_age <= stall_dir ? stall_age + 1 : 0;
    txf_age   <= txf_dir ? txf_age + 1 : 0;
  end

  // Scoreboard: kind 0 = mem write, 1 = UART byte, 2 = done, 3 = error.
  typedef struct {
    int          kind;
    logic [31:0] a;
    logic [31:0] d;
  } exp_t;

  exp_t expq[$];
  int   checks = 0, errors = 0;
  int   fin_cnt = 0, ld_cnt = 0, tx_cnt = 0;

  task automatic chk(input bit ok, input string nm,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push_exp(input int k, input logic [31:0] a,
                          input logic [31:0] d);
    exp_t e;
    e.kind = k; e.a = a; e.d = d;
    expq.push_back(e);
  endtask

  task automatic check_ev(input int k, input logic [31:0] a,
                          input logic [31:0] d);
    exp_t e;
    if (expq.size() == 0) begin
      chk(0, "unexpected_event", 32'(k), 32'hffff_ffff);
    end else begin
      e = expq.pop_front();
      chk(e.kind == k, "event_kind", 32'(k), 32'(e.kind));
      if (e.kind == k && k < 2) begin
        chk(a == e.a, "event_addr", a, e.a);
        chk(d == e.d, "event_data", d, e.d);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      chk(!(mem_read && mem_write), "strobe_overlap",
          {30'b0, mem_read, mem_write}, 32'h0);
      if (!mem_read && !mem_write)
        chk(address == 0 && write_data == 0, "bus_idle_zero",
            address | write_data, 32'h0);
      if (!ld_we)
        chk(ld_addr == 0 && ld_wdata == 0, "ld_idle_zero",
            ld_addr | ld_wdata, 32'h0);
      if (mem_read && address == UB)
        chk(stall_age < 2, "rx_read_during_stall", 32'(stall_age), 32'h1);
      if (mem_write)
        chk(txf_age < 2, "tx_write_while_full", 32'(txf_age), 32'h1);
      if (ld_we) begin
        check_ev(0, ld_addr, ld_wdata);
        ld_cnt++;
      end
      if (mem_write) begin
        check_ev(1, address, write_data);
        tx_cnt++;
      end
      if (done) begin
        check_ev(2, 0, 0);
        fin_cnt++;
      end
      if (error) begin
        check_ev(3, 0, 0);
        fin_cnt++;
      end
    end
  end

  assert property (@(posedge clk) disable iff (reset) !(mem_read && mem_write))
    else $error("FAIL strobe_overlap_assert");

  task automatic push_byte(input logic [7:0] b);
    rx_mem[rx_len[13:0]] = b;
    rx_len++;
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) push_byte(w[8*i +: 8]);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_fin(input int f0);
    int t;
    t = 0;
    while (fin_cnt == f0 && t < 40000) begin
      @(negedge clk);
      t++;
    end
    chk(fin_cnt != f0, "finish_timeout", 32'(t), 32'h0);
    @(negedge clk);
    chk(busy == 1'b0, "busy_after_finish", {31'b0, busy}, 32'h0);
    chk(expq.size() == 0, "scoreboard_drained", 32'(expq.size()), 32'h0);
    expq.delete();
  endtask

  // Reference model: expected responses follow from LEN alone.
  logic [31:0] fixed_w [2];

  task automatic run_load(input logic [31:0] len, input bit fixed,
                          input bit extra);
    int          f0;
    logic [31:0] w;
    f0 = fin_cnt;
    push_word(len);
    if (len == 0) begin
      push_exp(1, UB, 32'h06);
      push_exp(2, 0, 0);
    end else if (len > MW) begin
      push_exp(1, UB, 32'h15);
      push_exp(3, 0, 0);
    end else begin
      for (int i = 0; i < int'(len); i++) begin
        w = fixed ? fixed_w[i % 2] : $urandom;
        push_word(w);
        push_exp(0, LB + 32'(4 * i), w);
      end
      push_exp(1, UB, 32'h06);
      push_exp(2, 0, 0);
    end
    pulse_start();
    if (extra) begin
      for (int k = 0; k < 4; k++) begin
        repeat (3) @(negedge clk);
        if (busy) begin
          start = 1'b1;
          @(negedge clk);
          start = 1'b0;
        end
      end
    end
    wait_fin(f0);
  endtask

  task automatic chk_all_zero(input string nm);
    logic any;
    any = |{busy, done, error, mem_write, mem_read, ld_we,
            address, write_data, ld_addr, ld_wdata};
    chk(!any, nm, {31'b0, any}, 32'h0);
  endtask

  initial begin
    int          t, p0, l0, tx0, f0;
    logic [31:0] len;
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset_outputs");
    reset = 1'b0;
    @(negedge clk);
    chk_all_zero("idle_outputs");

    fixed_w[0] = 32'h1234_5678;
    fixed_w[1] = 32'hDEAD_BEEF;
    run_load(32'd2, 1'b1, 1'b0);
    run_load(32'd0, 1'b0, 1'b0);
    run_load(32'd1025, 1'b0, 1'b0);
    run_load(32'hFFFF_FFFF, 1'b0, 1'b0);

    // RX stall mid-word followed by a TX-full hold.
    f0 = fin_cnt;
    l0 = ld_cnt;
    push_word(32'd1);
    push_byte(8'hC3);
    push_byte(8'hB2);
    push_exp(0, LB, 32'h1122_B2C3);
    push_exp(1, UB, 32'h06);
    push_exp(2, 0, 0);
    txf_dir = 1'b1;
    pulse_start();
    t = 0;
    while (rd_ptr != rx_len && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk(rd_ptr == rx_len, "bp_prefix_consumed", 32'(rd_ptr), 32'(rx_len));
    stall_dir = 1'b1;
    p0 = rd_ptr;
    push_byte(8'h22);
    push_byte(8'h11);
    repeat (50) @(negedge clk);
    chk(rd_ptr == p0, "bp_no_read_in_stall", 32'(rd_ptr), 32'(p0));
    stall_dir = 1'b0;
    t = 0;
    while (ld_cnt == l0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk(ld_cnt != l0, "bp_word_written", 32'(ld_cnt), 32'(l0 + 1));
    tx0 = tx_cnt;
    repeat (20) @(negedge clk);
    chk(tx_cnt == tx0, "bp_no_tx_while_full", 32'(tx_cnt), 32'(tx0));
    txf_dir = 1'b0;
    wait_fin(f0);

    // Reset in the middle of a LEN=4 load.
    l0 = ld_cnt;
    push_word(32'd4);
    for (int i = 0; i < 4; i++) push_word($urandom);
    push_exp(0, LB, rx_mem[(rx_len - 16) & 16383] |
                    (32'(rx_mem[(rx_len - 15) & 16383]) << 8) |
                    (32'(rx_mem[(rx_len - 14) & 16383]) << 16) |
                    (32'(rx_mem[(rx_len - 13) & 16383]) << 24));
    pulse_start();
    t = 0;
    while (ld_cnt == l0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk(ld_cnt != l0, "rst_word0_written", 32'(ld_cnt), 32'(l0 + 1));
    reset = 1'b1;
    @(negedge clk);
    chk_all_zero("rst_midload_outputs");
    tx0 = tx_cnt;
    reset = 1'b0;
    @(negedge clk);
    chk_all_zero("rst_release_idle");
    rx_len = rd_ptr;
    expq.delete();
    run_load(32'd2, 1'b0, 1'b0);
    chk(tx_cnt == tx0 + 1, "rst_single_response", 32'(tx_cnt), 32'(tx0 + 1));

    // Randomized loads with random backpressure and stray starts.
    rand_bp = 1'b1;
    for (int n = 0; n < 10; n++) begin
      if ($urandom_range(0, 7) == 0)
        len = 32'd1025 + ($urandom & 32'h00ff_ffff);
      else
        len = 32'($urandom_range(0, 6));
      run_load(len, 1'b0, 1'b1);
    end
    rand_bp = 1'b0;

    run_load(32'd1024, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
